// File: rtl/glb_weight_streamer.sv
// rtl/glb_weight_streamer.sv - streams PE_SIZE-word weight tiles from a global buffer
// into a systolic array, one column enable per delivered row.
module glb_weight_streamer #(
   parameter int PE_SIZE    = 16,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10,
   parameter int MEM_DEPTH  = 896
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start_i,
   input  logic [ADDR_WIDTH-1:0]         base_addr_i,
   input  logic [7:0]                    num_tiles_i,
   input  logic                          reverse_i,
   input  logic                          stall_i,
   output logic                          mem_en_o,
   output logic [ADDR_WIDTH-1:0]         mem_addr_o,
   input  logic [PE_SIZE*DATA_WIDTH-1:0] mem_rdata_i,
   output logic [PE_SIZE*DATA_WIDTH-1:0] weight_data_o,
   output logic                          weight_valid_o,
   output logic [PE_SIZE-1:0]            weight_en_col_o,
   output logic                          tile_done_o,
   output logic                          busy_o,
   output logic                          err_o
);

   localparam int COL_W = (PE_SIZE > 1) ? $clog2(PE_SIZE) : 1;
   localparam int CNT_W = COL_W + 9;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t                          state_q, state_d;
   logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic [CNT_W-1:0]                total_q, total_d;
   logic                            rev_q, rev_d;
   logic                            err_q, err_d;
   logic [COL_W-1:0]                col_q, col_d;
   logic                            pend_q, pend_d;
   logic                            valid_q, valid_d;
   logic [PE_SIZE*DATA_WIDTH-1:0]   data_q, data_d;
   logic [PE_SIZE-1:0]              en_col_q, en_col_d;
   logic                            done_q, done_d;

   logic                            issue;
   logic                            range_ok;
   logic [31:0]                     end_addr;
   logic [COL_W-1:0]                col_idx;
   logic [PE_SIZE-1:0]              one_hot_base;

   assign end_addr     = 32'(base_addr_i) + 32'(num_tiles_i) * 32'(PE_SIZE);
   assign range_ok     = end_addr <= 32'(MEM_DEPTH);
   assign col_idx      = rev_q ? (COL_W'(PE_SIZE - 1) - col_q) : col_q;
   assign one_hot_base = PE_SIZE'(1);

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      cnt_d    = cnt_q;
      total_d  = total_q;
      rev_d    = rev_q;
      err_d    = err_q;
      col_d    = col_q;
      data_d   = data_q;
      en_col_d = '0;
      done_d   = 1'b0;
      issue    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i && num_tiles_i != 8'd0) begin
               if (range_ok) begin
                  state_d = FETCH;
                  addr_d  = base_addr_i;
                  cnt_d   = '0;
                  total_d = CNT_W'(num_tiles_i) * CNT_W'(PE_SIZE);
                  rev_d   = reverse_i;
                  err_d   = 1'b0;
                  col_d   = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         FETCH: begin
            if (!stall_i) begin
               issue  = 1'b1;
               addr_d = addr_q + ADDR_WIDTH'(1);
               cnt_d  = cnt_q + CNT_W'(1);
               if (cnt_q == total_q - CNT_W'(1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Leave once the last in-flight read has landed on the output.
            if (valid_q && !pend_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      pend_d  = issue;
      valid_d = pend_q;
      if (pend_q) begin
         data_d   = mem_rdata_i;
         en_col_d = one_hot_base << col_idx;
         done_d   = (col_q == COL_W'(PE_SIZE - 1));
         col_d    = done_d ? '0 : col_q + COL_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         cnt_q    <= '0;
         total_q  <= '0;
         rev_q    <= 1'b0;
         err_q    <= 1'b0;
         col_q    <= '0;
         pend_q   <= 1'b0;
         valid_q  <= 1'b0;
         data_q   <= '0;
         en_col_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
         total_q  <= total_d;
         rev_q    <= rev_d;
         err_q    <= err_d;
         col_q    <= col_d;
         pend_q   <= pend_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         en_col_q <= en_col_d;
         done_q   <= done_d;
      end
   end

   assign mem_en_o        = issue;
   assign mem_addr_o      = addr_q;
   assign weight_data_o   = data_q;
   assign weight_valid_o  = valid_q;
   assign weight_en_col_o = en_col_q;
   assign tile_done_o     = done_q;
   assign busy_o          = (state_q != IDLE);
   assign err_o           = err_q;

endmodule
